// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns RV32I loads/stores into word-aligned bus
// requests with byte enables, extends load data and stalls the pipeline meanwhile.
module mem_stage_lsu #(
  parameter int addr_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [addr_width-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  lsu_busy,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_reg, state_next;
  logic                  we_reg;
  logic [addr_width-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            be_reg;
  logic [2:0]            f3_reg;
  logic [1:0]            off_reg;
  logic [31:0]           rdata_reg;
  logic                  fault_reg;

  logic [1:0]  off;
  logic        illegal;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;
  logic        accept;

  assign off    = req_addr[1:0];
  assign accept = (state_reg == S_IDLE) && req_valid;

  always_comb begin
    illegal   = 1'b0;
    be_dec    = 4'b1111;
    wdata_dec = '0;
    case (req_funct3[1:0])
      2'b00: begin
        if (req_write) begin
          be_dec    = 4'b0001 << off;
          wdata_dec = {4{req_wdata[7:0]}};
        end
      end
      2'b01: begin
        illegal = off[0];
        if (req_write) begin
          be_dec    = off[1] ? 4'b1100 : 4'b0011;
          wdata_dec = {2{req_wdata[15:0]}};
        end
      end
      2'b10: begin
        illegal = |off;
        if (req_write) wdata_dec = req_wdata;
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (req_funct3[2] && req_write) illegal = 1'b1;
  end

  assign byte_sel = mem_rdata[{off_reg, 3'b000} +: 8];
  assign half_sel = mem_rdata[{off_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_reg[1:0])
      2'b00:   ext = {{24{~f3_reg[2] & byte_sel[7]}}, byte_sel};
      2'b01:   ext = {{16{~f3_reg[2] & half_sel[15]}}, half_sel};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (req_valid) state_next = illegal ? S_DONE : S_WAIT;
      S_WAIT:  if (mem_ready) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      f3_reg    <= '0;
      off_reg   <= '0;
      rdata_reg <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= req_write & ~illegal;
        addr_reg  <= {req_addr[addr_width-1:2], 2'b00};
        wdata_reg <= wdata_dec;
        be_reg    <= be_dec;
        f3_reg    <= req_funct3;
        off_reg   <= off;
        fault_reg <= illegal;
        if (illegal) rdata_reg <= '0;
      end
      // Stores complete with zero data so resp_rdata never leaks stale loads.
      if (state_reg == S_WAIT && mem_ready) rdata_reg <= we_reg ? 32'h0 : ext;
    end
  end

  assign lsu_busy   = accept || (state_reg == S_WAIT);
  assign mem_req    = (state_reg == S_WAIT);
  assign mem_we     = we_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_be     = be_reg;
  assign resp_valid = (state_reg == S_DONE);
  assign fault      = (state_reg == S_DONE) && fault_reg;
  assign resp_rdata = rdata_reg;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the pipelined RISC-V core. It sits between the EX/MEM pipeline register and a variable-latency data memory port. It converts RV32I load/store operations (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned bus requests with byte enables, and sign- or zero-extends load data. While an access is outstanding it raises a stall to the hazard logic, so the upstream pipeline registers hold.

## Interface
Parameters:
- `addr_width`, default 32: width of `req_addr` and `mem_addr`.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  EX/MEM holds a memory op (`ex_mem_memread | ex_mem_memwrite`).
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code.
- `req_addr`  in  addr_width  byte address (EX/MEM ALU result).
- `req_wdata`  in  32  store data, right-justified.
- `lsu_busy`  out  1  stall request; freezes PC, IF/ID, ID/EX, EX/MEM.
- `resp_valid`  out  1  one-cycle completion pulse (loads and stores).
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `fault`  out  1  one-cycle pulse with `resp_valid` on misaligned or illegal access.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  addr_width  word-aligned address, `{req_addr[addr_width-1:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_ready`  in  1  bus accepts/completes the access this cycle.
- `mem_rdata`  in  32  read word; valid when `mem_ready`=1 on a read.

## Operation
- States: IDLE, WAIT, DONE.
- `lsu_busy` = (IDLE & `req_valid`) | WAIT. It is combinational, so the accepting cycle already stalls.
- **IDLE, `req_valid`=1:**
  - Decode the access and latch address, funct3, offset `req_addr[1:0]`, byte enables and shifted write data.
  - Legal access → WAIT.
  - Illegal access → DONE with fault latched. No bus access is made.
- **Illegal access** is any of:
  - funct3[1:0]=11;
  - funct3 ∈ {100,101} with `req_write`=1;
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- **WAIT:**
  - `mem_req`=1, with `mem_we`/`mem_addr`/`mem_wdata`/`mem_be` driven from registers and stable until `mem_ready`.
  - `mem_ready`=1 → latch extended read data (stores latch 0) → DONE.
- **DONE:**
  - `resp_valid`=1, `lsu_busy`=0, `mem_req`=0.
  - `req_valid` is ignored this cycle, because EX/MEM still shows the completed op.
  - Always → IDLE.
- **Byte enables and store data:**
  - SB: `mem_be` = 1<<off, `mem_wdata` = {4{wdata[7:0]}}.
  - SH: `mem_be` = off[1] ? 1100 : 0011, `mem_wdata` = {2{wdata[15:0]}}.
  - SW: `mem_be` = 1111, `mem_wdata` = wdata.
  - Loads drive `mem_be`=1111.
- **Load extension:**
  - LB/LBU: byte `mem_rdata[8*off+:8]`, sign- or zero-extended.
  - LH/LHU: half `mem_rdata[16*off[1]+:16]`, sign- or zero-extended.
  - LW: whole word.
- **Reset** (`reset`=0 at an edge), including mid-WAIT:
  - State → IDLE.
  - All outputs → 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `resp_valid`, `resp_rdata`, `fault`.
  - A bus response arriving after reset is ignored.

## Timing
- Request accepted in cycle T (IDLE); `mem_req` is high from T+1.
- With `mem_ready` first high in cycle T+k (k≥1):
  - `resp_valid` is in T+k+1;
  - `lsu_busy` is high in T..T+k.
- Minimum legal access: 2 stall cycles, response in T+2.
- Fault: `lsu_busy` is high in T only; `resp_valid`=`fault`=1 in T+1; `mem_req` never asserts.
- `resp_rdata` is valid only while `resp_valid`=1 and holds until the next completion.
- `mem_ready` is sampled only in WAIT; a high `mem_ready` in IDLE or DONE is ignored.
- Back-to-back ops: a new op presented in the cycle after DONE is accepted in IDLE. Best case is one access per 3 cycles.

## Test plan
- LW at 0x0000_0010, `mem_ready` tied high, `mem_rdata`=0xDEAD_BEEF:
  - `mem_addr`=0x10, `mem_be`=1111, `mem_req` at T+1;
  - `resp_rdata`=0xDEAD_BEEF with `resp_valid` at T+2;
  - `lsu_busy` high T..T+1 only.
- LB/LBU at 0x13 with `mem_rdata`=0x80FF_7F01 → LB gives 0xFFFF_FF80, LBU gives 0x0000_0080.
- LH at 0x12 with `mem_rdata`=0x80FF_7F01 → 0xFFFF_80FF.
- SB at 0x21 with wdata 0x1234_56AB, `mem_ready` delayed 3 cycles:
  - `mem_be`=0010, `mem_wdata`=0xABAB_ABAB, `mem_we`=1;
  - outputs stable across all 3 wait cycles; `resp_valid` one cycle after `mem_ready`; `resp_rdata`=0.
- SW at 0x22:
  - `fault`+`resp_valid` at T+1, `mem_req` never high, `lsu_busy` high only in T.
  - LH at 0x11 gives the same fault behaviour.
- Reset asserted (`reset`=0) during WAIT:
  - next cycle `mem_req`=0 and state IDLE;
  - a later `mem_ready` pulse yields no `resp_valid`;
  - a following LW completes normally.
